pipe_id_ex: RTL and testbench
=============================

# pipe_id_ex

Decode-stage slice of the 4-stage processor pipeline: the IF/ID instruction register, the opcode control decoder, and the ID/EX register that carries operands, the extended immediate and control bits into execute. Register-file reads and immediate extension sit outside the block. The block supplies their field addresses and select, then re-registers their results alongside the decoded controls.

## Interface
- N, 32, datapath width of instruction, operands and immediate
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- instruction_i  in  N  fetched instruction from IF
- Stall_i  in  1  hold IF/ID contents (see Configuration)
- Flush_i  in  1  insert bubble into ID/EX (see Configuration)
- RD1_i, RD2_i  in  N  register-file read data for A1/A2
- Extend_i  in  N  extended immediate from external extender
- A1_o, A2_o  out  4  register-file read addresses, combinational from IF/ID
- Imm_o  out  20  instruction[19:0] to extender, combinational
- ExtendSelect_o  out  2  extender mode, combinational
- RD1_o, RD2_o, Extend_o  out  N  registered operands
- A3_o  out  4  registered destination register
- RF_WE_o, BranchSelect_o, ALUOpBSelect_o, SetFlags_o, MemWE_o, WBSelect_o  out  1  registered controls
- ALUControl_o  out  2  registered ALU op: 00 add, 01 sub, 10 and, 11 or

## Operation
- Instruction fields: OpCode[31:28], A1[27:24], A2[23:20], A3[19:16], imm[15:0].
- The decoder is purely combinational from the IF/ID opcode. Signals not listed for an opcode are 0:
  - 0x0 NOP: all 0
  - 0x1 ADD: RF_WE
  - 0x2 SUB: RF_WE, ALU=01
  - 0x3 AND: RF_WE, ALU=10
  - 0x4 OR: RF_WE, ALU=11
  - 0x5 ADDI: RF_WE, ALUOpB=1, ExtSel=00
  - 0x6 SUBI: RF_WE, ALUOpB=1, ALU=01
  - 0x7 CMP: SetFlags, ALU=01
  - 0x8 LDR: RF_WE, ALUOpB=1, WBSelect=1
  - 0x9 STR: MemWE, ALUOpB=1
  - 0xA B: BranchSelect, ExtSel=01
  - 0xB MOVI: RF_WE, ALUOpB=1, ExtSel=10
  - 0xC–0xF: decoded as NOP
- ID/EX captures RD1_i, RD2_i, Extend_i, the A3 field and all decoded controls except ExtendSelect.
- Flush (when enabled) zeroes only the ID/EX control bits: RF_WE, BranchSelect, SetFlags, MemWE, ALUOpBSelect, WBSelect and ALUControl. Data fields and A3 still load.
- Stall (when enabled) holds IF/ID. ID/EX still loads, so the same decoded instruction re-issues.
- Flush has priority over stall for ID/EX. Both may be asserted together.

## Timing
- IF/ID: 1 cycle. Decode outputs and A1_o, A2_o, Imm_o and ExtendSelect_o are valid in the same cycle as the IF/ID content.
- ID/EX: 1 further cycle. Total instruction_i to control outputs is 2 rising edges.
- RD1_i, RD2_i and Extend_i must be settled before the edge that loads ID/EX; they are sampled in the same cycle as the decode.
- RST low: every register clears to 0 immediately, independent of CLK. IF/ID = 0 decodes as NOP, so every output reads 0.
- Reset deasserting mid-stream: the first edge after release loads normally; no extra bubble is inserted.

## Configuration
- PIPE_STALL_FLUSH_EN defined: Stall_i and Flush_i act as described in Operation.
- PIPE_STALL_FLUSH_EN undefined: both ports remain but are ignored, and both registers load on every edge.

## Structure
- Shared package pipe_pkg holds:
  - opcode enum
  - ALUControl constants
  - ExtendSelect constants
  - field bit-position localparams
  - packed struct of the ID/EX control bits
- One sub-module, control_unit: the combinational opcode decoder, instantiated once.

## Test plan
- Reset: RST low with instruction_i=0x1234_5678 and RD1_i=5 -> all outputs 0 during reset and immediately on assertion, without a clock edge.
- ADD: instruction_i=0x1230_0000 -> after 1 edge A1_o=2, A2_o=3; after 2 edges RF_WE_o=1, A3_o=0, ALUControl_o=00, others 0, RD1_o/RD2_o equal the RD1_i/RD2_i sampled at the second edge.
- LDR vs STR: 0x8120_0010 -> WBSelect_o=1, ALUOpBSelect_o=1, RF_WE_o=1, Extend_o=Extend_i; 0x9120_0010 -> MemWE_o=1, RF_WE_o=0.
- Opcode sweep: drive all 16 opcodes back-to-back -> each control vector matches the decode list two edges later; 0xC–0xF give all-zero controls.
- Flush/stall with macro defined: Flush_i=1 on an ADD -> ID/EX controls 0 while RD1_o still loads; Stall_i=1 for 2 cycles -> A1_o unchanged and the same controls appear on 3 consecutive cycles.
- Macro undefined: Stall_i=Flush_i=1 -> pipeline advances every cycle, identical to both inputs at 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-stage slice: opcodes, ALU and
// extender selects, instruction field positions and the ID/EX control bundle.
package pipe_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_SUBI = 4'h6,
    OP_CMP  = 4'h7,
    OP_LDR  = 4'h8,
    OP_STR  = 4'h9,
    OP_B    = 4'hA,
    OP_MOVI = 4'hB
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] EXT_IMM  = 2'b00;
  localparam logic [1:0] EXT_BR   = 2'b01;
  localparam logic [1:0] EXT_MOVI = 2'b10;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 28;
  localparam int unsigned A1_MSB    = 27;
  localparam int unsigned A1_LSB    = 24;
  localparam int unsigned A2_MSB    = 23;
  localparam int unsigned A2_LSB    = 20;
  localparam int unsigned A3_MSB    = 19;
  localparam int unsigned A3_LSB    = 16;
  localparam int unsigned IMMX_MSB  = 19;

  typedef struct packed {
    logic       rf_we;
    logic       branch_sel;
    logic       alu_opb_sel;
    logic       set_flags;
    logic       mem_we;
    logic       wb_sel;
    logic [1:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/pipe_id_ex_control_unit.sv
// Combinational opcode decoder; unlisted opcodes (0xC-0xF) decode as NOP.
module control_unit
  import pipe_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic [1:0] ext_sel_o
);

  always_comb begin
    ctrl_o    = '0;
    ext_sel_o = EXT_IMM;
    case (opcode_i)
      OP_ADD:  ctrl_o.rf_we = 1'b1;
      OP_SUB:  begin ctrl_o.rf_we = 1'b1; ctrl_o.alu_ctrl = ALU_SUB; end
      OP_AND:  begin ctrl_o.rf_we = 1'b1; ctrl_o.alu_ctrl = ALU_AND; end
      OP_OR:   begin ctrl_o.rf_we = 1'b1; ctrl_o.alu_ctrl = ALU_OR;  end
      OP_ADDI: begin ctrl_o.rf_we = 1'b1; ctrl_o.alu_opb_sel = 1'b1; end
      OP_SUBI: begin
        ctrl_o.rf_we       = 1'b1;
        ctrl_o.alu_opb_sel = 1'b1;
        ctrl_o.alu_ctrl    = ALU_SUB;
      end
      OP_CMP:  begin ctrl_o.set_flags = 1'b1; ctrl_o.alu_ctrl = ALU_SUB; end
      OP_LDR:  begin
        ctrl_o.rf_we       = 1'b1;
        ctrl_o.alu_opb_sel = 1'b1;
        ctrl_o.wb_sel      = 1'b1;
      end
      OP_STR:  begin ctrl_o.mem_we = 1'b1; ctrl_o.alu_opb_sel = 1'b1; end
      OP_B:    begin ctrl_o.branch_sel = 1'b1; ext_sel_o = EXT_BR; end
      OP_MOVI: begin
        ctrl_o.rf_we       = 1'b1;
        ctrl_o.alu_opb_sel = 1'b1;
        ext_sel_o          = EXT_MOVI;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_id_ex.sv
// IF/ID register, decoder and ID/EX register of the decode stage.
// Stall_i/Flush_i take effect only when PIPE_STALL_FLUSH_EN is defined.
module pipe_id_ex
  import pipe_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] instruction_i,
  input  logic         Stall_i,
  input  logic         Flush_i,
  input  logic [N-1:0] RD1_i,
  input  logic [N-1:0] RD2_i,
  input  logic [N-1:0] Extend_i,
  output logic [3:0]   A1_o,
  output logic [3:0]   A2_o,
  output logic [19:0]  Imm_o,
  output logic [1:0]   ExtendSelect_o,
  output logic [N-1:0] RD1_o,
  output logic [N-1:0] RD2_o,
  output logic [N-1:0] Extend_o,
  output logic [3:0]   A3_o,
  output logic         RF_WE_o,
  output logic         BranchSelect_o,
  output logic         ALUOpBSelect_o,
  output logic         SetFlags_o,
  output logic         MemWE_o,
  output logic         WBSelect_o,
  output logic [1:0]   ALUControl_o
);

  logic [N-1:0] ifid_q, ifid_d;
  logic [N-1:0] rd1_q, rd2_q, ext_q;
  logic [3:0]   a3_q;
  ctrl_t        ctrl_q, ctrl_d, dec;

  control_unit u_control_unit (
    .opcode_i  (ifid_q[OP_MSB:OP_LSB]),
    .ctrl_o    (dec),
    .ext_sel_o (ExtendSelect_o)
  );

`ifdef PIPE_STALL_FLUSH_EN
  // Flush only kills controls; operands and A3 keep flowing into ID/EX.
  always_comb begin
    ifid_d = Stall_i ? ifid_q : instruction_i;
    ctrl_d = Flush_i ? '0 : dec;
  end
`else
  logic unused_stall_flush;
  assign unused_stall_flush = Stall_i ^ Flush_i;

  always_comb begin
    ifid_d = instruction_i;
    ctrl_d = dec;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ifid_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      ext_q  <= '0;
      a3_q   <= '0;
      ctrl_q <= '0;
    end else begin
      ifid_q <= ifid_d;
      rd1_q  <= RD1_i;
      rd2_q  <= RD2_i;
      ext_q  <= Extend_i;
      a3_q   <= ifid_q[A3_MSB:A3_LSB];
      ctrl_q <= ctrl_d;
    end
  end

  assign A1_o           = ifid_q[A1_MSB:A1_LSB];
  assign A2_o           = ifid_q[A2_MSB:A2_LSB];
  assign Imm_o          = ifid_q[IMMX_MSB:0];
  assign RD1_o          = rd1_q;
  assign RD2_o          = rd2_q;
  assign Extend_o       = ext_q;
  assign A3_o           = a3_q;
  assign RF_WE_o        = ctrl_q.rf_we;
  assign BranchSelect_o = ctrl_q.branch_sel;
  assign ALUOpBSelect_o = ctrl_q.alu_opb_sel;
  assign SetFlags_o     = ctrl_q.set_flags;
  assign MemWE_o        = ctrl_q.mem_we;
  assign WBSelect_o     = ctrl_q.wb_sel;
  assign ALUControl_o   = ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Self-checking bench for pipe_id_ex: opcode table, directed corner
// sequences and randomized traffic against a two-stage reference model.
module tb_pipe_id_ex;

`ifdef PIPE_STALL_FLUSH_EN
  localparam bit SF_EN = 1'b1;
`else
  localparam bit SF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] rd1 = '0, rd2 = '0, ext = '0;
  logic [3:0]  a1, a2, a3;
  logic [19:0] imm;
  logic [1:0]  ext_sel, alu;
  logic [31:0] rd1_o, rd2_o, ext_o;
  logic        rf_we, br, opb, sf, mem_we, wb;

  always #5 clk = ~clk;

  pipe_id_ex #(.N(32)) dut (
    .CLK(clk), .RST(rst_n), .instruction_i(instr),
    .Stall_i(stall), .Flush_i(flush),
    .RD1_i(rd1), .RD2_i(rd2), .Extend_i(ext),
    .A1_o(a1), .A2_o(a2), .Imm_o(imm), .ExtendSelect_o(ext_sel),
    .RD1_o(rd1_o), .RD2_o(rd2_o), .Extend_o(ext_o), .A3_o(a3),
    .RF_WE_o(rf_we), .BranchSelect_o(br), .ALUOpBSelect_o(opb),
    .SetFlags_o(sf), .MemWE_o(mem_we), .WBSelect_o(wb), .ALUControl_o(alu)
  );

  // {opcode, expected controls {rf_we,br,opb,sf,mem_we,wb,alu[1:0]}, ext_sel}
  typedef struct {
    logic [3:0] op;
    logic [7:0] ctrl;
    logic [1:0] ext;
  } vec_t;
  vec_t tbl[16];

  int checks = 0;
  int errors = 0;

  // Reference model state: what each pipeline register should hold.
  logic [31:0] m_ifid = '0;
  logic [7:0]  m_ctrl = '0;
  logic [31:0] m_rd1 = '0, m_rd2 = '0, m_ext = '0;
  logic [3:0]  m_a3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("A1", {28'd0, a1}, {28'd0, m_ifid[27:24]});
    chk("A2", {28'd0, a2}, {28'd0, m_ifid[23:20]});
    chk("Imm", {12'd0, imm}, {12'd0, m_ifid[19:0]});
    chk("ExtSel", {30'd0, ext_sel}, {30'd0, tbl[m_ifid[31:28]].ext});
    chk("ctrl", {24'd0, rf_we, br, opb, sf, mem_we, wb, alu}, {24'd0, m_ctrl});
    chk("RD1", rd1_o, m_rd1);
    chk("RD2", rd2_o, m_rd2);
    chk("Ext", ext_o, m_ext);
    chk("A3", {28'd0, a3}, {28'd0, m_a3});
  endtask

  task automatic model_reset();
    m_ifid = '0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_ext = '0; m_a3 = '0;
  endtask

  // Apply one cycle of inputs, advance model and DUT one edge, then compare.
  task automatic tick(input logic [31:0] ins, input logic st, input logic fl);
    instr = ins; stall = st; flush = fl;
    rd1 = $urandom; rd2 = $urandom; ext = $urandom;
    m_ctrl = (SF_EN && fl) ? 8'h00 : tbl[m_ifid[31:28]].ctrl;
    m_rd1 = rd1; m_rd2 = rd2; m_ext = ext;
    m_a3 = m_ifid[19:16];
    if (!(SF_EN && st)) m_ifid = ins;
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    tbl[0]  = '{4'h0, 8'b0000_0000, 2'b00};
    tbl[1]  = '{4'h1, 8'b1000_0000, 2'b00};
    tbl[2]  = '{4'h2, 8'b1000_0001, 2'b00};
    tbl[3]  = '{4'h3, 8'b1000_0010, 2'b00};
    tbl[4]  = '{4'h4, 8'b1000_0011, 2'b00};
    tbl[5]  = '{4'h5, 8'b1010_0000, 2'b00};
    tbl[6]  = '{4'h6, 8'b1010_0001, 2'b00};
    tbl[7]  = '{4'h7, 8'b0001_0001, 2'b00};
    tbl[8]  = '{4'h8, 8'b1010_0100, 2'b00};
    tbl[9]  = '{4'h9, 8'b0010_1000, 2'b00};
    tbl[10] = '{4'hA, 8'b0100_0000, 2'b01};
    tbl[11] = '{4'hB, 8'b1010_0000, 2'b10};
    for (int i = 12; i < 16; i++) tbl[i] = '{i[3:0], 8'h00, 2'b00};

    // Reset asserted before any clock edge, with busy inputs.
    instr = 32'h1234_5678; rd1 = 32'd5;
    #1 rst_n = 1'b0;
    #2 model_reset(); check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;

    // ADD: addresses after one edge, controls after two.
    tick(32'h1230_0000, 1'b0, 1'b0);
    chk("ADD_A1", {28'd0, a1}, 32'd2);
    chk("ADD_A2", {28'd0, a2}, 32'd3);
    tick(32'h0000_0000, 1'b0, 1'b0);
    chk("ADD_RFWE", {31'd0, rf_we}, 32'd1);
    chk("ADD_RD1", rd1_o, rd1);

    // LDR then STR.
    tick(32'h8120_0010, 1'b0, 1'b0);
    tick(32'h9120_0010, 1'b0, 1'b0);
    chk("LDR_WB", {31'd0, wb}, 32'd1);
    chk("LDR_EXT", ext_o, ext);
    tick(32'h0000_0000, 1'b0, 1'b0);
    chk("STR_MEM", {30'd0, mem_we, rf_we}, 32'b10);

    // Back-to-back opcode sweep from the table.
    for (int i = 0; i < 16; i++)
      tick({tbl[i].op, 28'(($urandom))}, 1'b0, 1'b0);
    tick(32'h0, 1'b0, 1'b0);
    tick(32'h0, 1'b0, 1'b0);

    // Flush on an ADD, then a two-cycle stall on a SUB.
    tick(32'h1450_0000, 1'b0, 1'b0);
    tick(32'h2670_0000, 1'b0, 1'b1);
    tick(32'h3000_0000, 1'b1, 1'b0);
    tick(32'h4000_0000, 1'b1, 1'b0);
    tick(32'h0000_0000, 1'b0, 1'b0);
    tick(32'h0000_0000, 1'b1, 1'b1);

    // Asynchronous reset mid-stream, checked without a clock edge.
    tick(32'hB9AF_1234, 1'b0, 1'b0);
    tick(32'h7000_0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 model_reset(); check_all();
    @(posedge clk); #1 check_all();
    rst_n = 1'b1;
    tick(32'h6ABC_0001, 1'b0, 1'b0);
    tick(32'h0, 1'b0, 1'b0);

    // Randomized traffic with occasional stall/flush.
    for (int i = 0; i < 300; i++)
      tick($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
